// File: rtl/ipv_deserializer.sv
// Serial-to-parallel vector assembler: packs LANES-bit beats (first beat in the LSBs) into a
// K-bit vector, with early termination, zero fill, a length report and DELAY alignment stages.
module ipv_deserializer #(
  parameter  int K     = 4,
  parameter  int LANES = 1,
  parameter  int DELAY = 3,
  localparam int LW    = $clog2(K + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [LANES-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  output logic [K-1:0]     out_data,
  output logic [LW-1:0]    out_len
);
  localparam int B  = K / LANES;
  localparam int CW = (B > 1) ? $clog2(B) : 1;

  logic [CW-1:0] r_idx;
  logic [K-1:0]  r_acc;
  logic          r_vld  [DELAY+1];
  logic [K-1:0]  r_data [DELAY+1];
  logic [LW-1:0] r_len  [DELAY+1];

  logic [K-1:0]  w_beat;
  logic [K-1:0]  w_merged;
  logic          w_done;
  logic [LW-1:0] w_len;

  // Bits above the current beat are always zero in r_acc, so OR-ing is the same as writing the slice.
  always_comb begin
    w_beat   = K'(in_data) << (int'(r_idx) * LANES);
    w_merged = r_acc | w_beat;
    w_done   = in_valid && (in_last || (r_idx == CW'(B - 1)));
    w_len    = LW'((int'(r_idx) + 1) * LANES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (in_valid) begin
      if (w_done) begin
        r_idx <= '0;
        r_acc <= '0;
      end else begin
        r_idx <= r_idx + CW'(1);
        r_acc <= w_merged;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= DELAY; i++) begin
        r_vld[i]  <= 1'b0;
        r_data[i] <= '0;
        r_len[i]  <= '0;
      end
    end else begin
      r_vld[0]  <= w_done;
      r_data[0] <= w_done ? w_merged : '0;
      r_len[0]  <= w_done ? w_len : '0;
      for (int i = 1; i <= DELAY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_data[i] <= r_data[i-1];
        r_len[i]  <= r_len[i-1];
      end
    end
  end

  assign out_valid = r_vld[DELAY];
  assign out_data  = r_data[DELAY];
  assign out_len   = r_len[DELAY];

endmodule

// File: tb/tb_ipv_deserializer.sv
// Bench for ipv_deserializer: four parameter sets, directed plus random beats, every output cycle
// compared against an arithmetic model that sums beats into vectors and schedules their strobes.
module tb_ipv_deserializer;

  typedef struct {
    bit rst;
    int gap;
    int data;
    bit last;
  } beat_t;

  typedef struct {
    int          due;
    logic [63:0] data;
    int          len;
  } exp_t;

  logic clk;
  int   total = 0;
  int   bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int cfg_k(input int g);
    int r;
    case (g)
      0:       r = 4;
      1:       r = 8;
      2:       r = 8;
      default: r = 16;
    endcase
    return r;
  endfunction

  function automatic int cfg_l(input int g);
    int r;
    case (g)
      0:       r = 1;
      1:       r = 2;
      2:       r = 2;
      default: r = 4;
    endcase
    return r;
  endfunction

  function automatic int cfg_d(input int g);
    int r;
    case (g)
      0:       r = 3;
      1:       r = 1;
      2:       r = 0;
      default: r = 2;
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gen_cfg
    localparam int GK = cfg_k(g);
    localparam int GL = cfg_l(g);
    localparam int GD = cfg_d(g);
    localparam int GB = GK / GL;
    localparam int GW = $clog2(GK + 1);

    logic          rst_n;
    logic          in_valid;
    logic [GL-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic [GK-1:0] out_data;
    logic [GW-1:0] out_len;
    bit            done_g;

    int            m_cyc = 0;
    int            m_n   = 0;
    logic [63:0]   m_vec = '0;
    exp_t          m_q[$];
    beat_t         sq[$];

    ipv_deserializer #(.K(GK), .LANES(GL), .DELAY(GD)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_len   (out_len)
    );

    // Model: count edges, accumulate beat values by place weight, schedule the strobe GD edges later.
    initial forever begin
      @(posedge clk);
      m_cyc++;
      if (!rst_n) begin
        m_n   = 0;
        m_vec = '0;
        m_q.delete();
      end else if (in_valid) begin
        m_vec = m_vec + (64'(in_data) << (m_n * GL));
        m_n++;
        if (in_last || m_n == GB) begin
          m_q.push_back('{m_cyc + GD, m_vec, m_n * GL});
          m_n   = 0;
          m_vec = '0;
        end
      end
    end

    initial begin : checker_blk
      exp_t        e;
      logic        ev;
      logic [63:0] ed;
      int          el;
      forever begin
        @(negedge clk);
        ev = 1'b0;
        ed = '0;
        el = 0;
        if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
          e  = m_q.pop_front();
          ev = 1'b1;
          ed = e.data;
          el = e.len;
        end
        chk_val($sformatf("c%0d_valid@%0d", g, m_cyc), 64'(out_valid), 64'(ev));
        chk_val($sformatf("c%0d_data@%0d", g, m_cyc), 64'(out_data), ed);
        chk_val($sformatf("c%0d_len@%0d", g, m_cyc), 64'(out_len), 64'(el));
      end
    end

    initial begin : stim
      int d4[4];
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      rst_n    = 1'b0;
      done_g   = 1'b0;

      case (g)
        0: begin
          d4 = '{1, 0, 1, 1};
          for (int i = 0; i < 4; i++) sq.push_back('{1'b0, 0, d4[i], 1'b0});
          for (int i = 0; i < 4; i++) sq.push_back('{1'b0, int'($urandom_range(5)), d4[i], 1'b0});
          sq.push_back('{1'b0, 2, 1, 1'b0});
          sq.push_back('{1'b0, 0, 1, 1'b0});
          sq.push_back('{1'b1, 1, 0, 1'b0});
          d4 = '{0, 1, 1, 0};
          for (int i = 0; i < 4; i++) sq.push_back('{1'b0, 0, d4[i], 1'b0});
        end
        1: begin
          sq.push_back('{1'b0, 0, 3, 1'b0});
          sq.push_back('{1'b0, 0, 1, 1'b1});
          for (int i = 0; i < 4; i++) sq.push_back('{1'b0, 0, int'($urandom), 1'b0});
        end
        2: begin
          for (int i = 1; i <= 3; i++) sq.push_back('{1'b0, 0, i, 1'b1});
        end
        default: begin
          d4 = '{10, 11, 12, 13};
          for (int i = 0; i < 4; i++) sq.push_back('{1'b0, 0, d4[i], 1'b0});
          d4 = '{14, 15, 0, 1};
          for (int i = 0; i < 4; i++) sq.push_back('{1'b0, 0, d4[i], 1'b0});
        end
      endcase

      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(60) == 0)
          sq.push_back('{1'b1, 1 + int'($urandom_range(1)), 0, 1'b0});
        else
          sq.push_back('{1'b0, ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0,
                         int'($urandom), ($urandom_range(3) == 0)});
      end

      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      foreach (sq[i]) begin
        if (sq[i].rst) begin
          @(negedge clk);
          #2;
          rst_n    = 1'b0;
          in_valid = 1'b0;
          in_last  = 1'b0;
          #1;
          chk_val($sformatf("c%0d_rst_valid", g), 64'(out_valid), 64'(0));
          chk_val($sformatf("c%0d_rst_data", g), 64'(out_data), 64'(0));
          chk_val($sformatf("c%0d_rst_len", g), 64'(out_len), 64'(0));
          repeat (sq[i].gap) @(negedge clk);
          #2 rst_n = 1'b1;
        end else begin
          repeat (sq[i].gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = GL'($urandom);
            in_last  = 1'($urandom);
          end
          @(negedge clk);
          in_valid = 1'b1;
          in_data  = GL'(sq[i].data);
          in_last  = sq[i].last;
        end
      end

      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (GD + 3) @(negedge clk);
      chk_val($sformatf("c%0d_leftover", g), 64'(m_q.size()), 64'(0));
      done_g = 1'b1;
    end
  end

  initial begin : main
    int t;
    t = 0;
    while (!(gen_cfg[0].done_g && gen_cfg[1].done_g && gen_cfg[2].done_g && gen_cfg[3].done_g)
           && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk_val("timeout", 64'(t < 20000), 64'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ipv_deserializer.md
# ipv_deserializer

Parametrised serial-to-parallel vector assembler, successor to the single-bit fixed-width IPV reducer. It collects `LANES` bits per valid beat into a `K`-bit vector, first beat in the LSBs. It supports early termination with zero fill and reports the valid length of each vector. Completed vectors pass through a fixed `DELAY`-stage alignment pipeline, so the output lines up with the downstream datapath.

## Interface
- `K`, 4, output vector width in bits; 2..32.
- `LANES`, 1, bits accepted per input beat; 1..K; K must be a multiple of LANES.
- `DELAY`, 3, extra output alignment stages; 0..8.
- Derived `B` = K/LANES, beats per full vector. `CW` = max(1, $clog2(B)). `LW` = $clog2(K+1).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  beat qualifier; `in_data` and `in_last` are ignored when low.
- `in_data`  in  LANES  beat payload.
- `in_last`  in  1  the current beat terminates the vector early; only meaningful with `in_valid`.
- `out_valid`  out  1  single-cycle strobe marking a completed vector.
- `out_data`  out  K  assembled vector; all-zero whenever `out_valid`=0.
- `out_len`  out  LW  number of valid bits in `out_data` (multiple of LANES, 1..K); zero whenever `out_valid`=0.

## Operation
- State:
  - beat index `idx` (CW bits, 0..B-1)
  - accumulator `acc` (K bits)
  - DELAY+1 output stages, each holding {valid, data, len}
- Accepted beat (in_valid=1):
  - `in_data` is written to `acc[idx*LANES +: LANES]`.
  - The beat completes the vector if idx==B-1 or in_last=1.
- Completing beat:
  - Stage 0 loads valid=1.
  - data = `acc` with the current beat merged in; all bits above the current beat are 0.
  - len = (idx+1)*LANES.
  - `acc` clears to 0 and `idx` returns to 0.
- Non-completing beat: `idx` increments; stage 0 loads all-zero.
- in_valid=0: `idx` and `acc` hold; stage 0 loads all-zero. Gaps of any length between beats are legal.
- in_last on the first beat (idx==0): a 1-beat vector is emitted with len=LANES.
- in_last on beat B-1 is redundant; the result is identical to a normal completion.
- The pipeline advances every cycle. There is no backpressure, so the downstream must accept every strobe.
- Stage i+1 loads stage i. Outputs are driven directly from stage DELAY.
- Back-to-back vectors: a completing beat followed next cycle by the first beat of a new vector is legal. It produces strobes on consecutive output cycles when the vectors are 1-beat long. Otherwise the strobes are spaced by the beat count.
- Reset:
  - `idx`=0, `acc`=0, all stages cleared.
  - `out_valid`=0, `out_data`=0, `out_len`=0.
  - Assertion mid-vector discards the partial vector and any in-flight strobes; nothing is emitted after release.
- Width rules:
  - `out_len` is computed at LW bits and must not truncate at len=K.
  - `idx` wraps only through completion, never by overflow.

## Timing
- Latency: a completing beat sampled on edge E gives `out_valid`=1 during the cycle after edge E+DELAY. That is DELAY+1 cycles from the input cycle.
- With DELAY=0, the output is registered once and appears right after edge E.
- `out_valid` is high for exactly one cycle per completed vector.
- `out_data` and `out_len` are stable for that cycle and are zero in all other cycles.
- Throughput: one beat per cycle sustained; no dead cycle between vectors.
- Async reset clears outputs immediately, without waiting for a clock edge.

## Test plan
- Full vector (K=4, LANES=1, DELAY=3): bits 1,0,1,1 on consecutive cycles -> one strobe 4 cycles after the last beat; out_data=4'b1101, out_len=4.
- Gapped input (same config): the beats 1,0,1,1 separated by 0-5 idle cycles -> identical output, timed from the last beat; out_valid=0 in every other cycle.
- Early termination (K=8, LANES=2, DELAY=1): beats 2'b11, 2'b01 with in_last on the second -> out_data=8'h07, out_len=4, strobe 2 cycles later; the next vector starts at idx 0.
- Back-to-back single-beat (K=8, LANES=2, DELAY=0): in_last every cycle, data 1,2,3 -> three consecutive strobes with out_data 01,02,03 and out_len=2 each.
- Wide multi-lane (K=16, LANES=4, DELAY=2): beats A,B,C,D continuous, then E,F,0,1 continuous -> out_data 16'hDCBA then 16'h10FE, each len=16, strobes 4 cycles apart.
- Reset mid-operation (K=4, LANES=1, DELAY=3):
  - Stimulus: 2 beats, then rst_n low for 1 cycle, then bits 0,1,1,0.
  - Required: outputs 0 during reset; no strobe from the discarded beats; a single strobe follows with out_data=4'b0110 and out_len=4.
